// File: rtl/mod_147_rx_link_status_pkg.sv
// ---------------------------------------------------------------------------
// mod_147_rx_link_status_pkg
// Shared definitions for the 10BASE-T1S receive link status block:
//   - pcs_status encodings (PCS_OK / PCS_NOT_OK)
//   - code-group sync state encodings (NO_SYNC / SYNC / SYNC_CHECK)
//   - is_invalid_5b(): classifies a received 5B code-group
// ---------------------------------------------------------------------------
package mod_147_rx_link_status_pkg;

  localparam logic PCS_OK     = 1'b0;
  localparam logic PCS_NOT_OK = 1'b1;

  typedef enum logic [1:0] {
    NO_SYNC    = 2'd0,
    SYNC       = 2'd1,
    SYNC_CHECK = 2'd2
  } sync_state_e;

  // The eight code-groups that are never transmitted; the remaining 24 are
  // the 16 data groups plus the I J K T R S Q H control groups.
  function automatic logic is_invalid_5b(input logic [4:0] sym);
    case (sym)
      5'b00001, 5'b00010, 5'b00011, 5'b00101,
      5'b00110, 5'b01000, 5'b01100, 5'b10000: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mod_147_sd_filter.sv
// ---------------------------------------------------------------------------
// mod_147_sd_filter
// Debounces the raw PMA signal_detect into loc_rcv_status.
// The counter tracks consecutive cycles in which signal_detect disagrees with
// the current output; any agreeing cycle clears it. The output toggles once
// SD_ON_CYC (rising) or SD_OFF_CYC (falling) disagreeing cycles are seen.
// Ports:
//   clk            in  receive clock
//   reset_n        in  async reset, active low
//   pma_reset      in  sync reset, active high
//   signal_detect  in  raw energy detect
//   loc_rcv_status out debounced receiver-qualified flag
// ---------------------------------------------------------------------------
module mod_147_sd_filter #(
  parameter int unsigned SD_ON_CYC  = 16,
  parameter int unsigned SD_OFF_CYC = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pma_reset,
  input  logic signal_detect,
  output logic loc_rcv_status
);

  localparam int unsigned CMAX = (SD_ON_CYC > SD_OFF_CYC) ? SD_ON_CYC : SD_OFF_CYC;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  logic [CW-1:0] r_cnt;
  logic          r_loc;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_loc_nxt;
  logic [CW-1:0] w_thr;

  always_comb begin
    w_thr     = r_loc ? CW'(SD_OFF_CYC) : CW'(SD_ON_CYC);
    w_cnt_nxt = r_cnt;
    w_loc_nxt = r_loc;
    if (signal_detect == r_loc) begin
      w_cnt_nxt = '0;
    end else if (r_cnt >= w_thr - CW'(1)) begin
      // This cycle is the threshold-th disagreeing one: toggle and restart.
      // The counter therefore never exceeds the threshold and cannot wrap.
      w_loc_nxt = ~r_loc;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_loc <= 1'b0;
    end else if (pma_reset) begin
      r_cnt <= '0;
      r_loc <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_loc <= w_loc_nxt;
    end
  end

  assign loc_rcv_status = r_loc;

endmodule

// File: rtl/mod_147_rx_link_status.sv
// ---------------------------------------------------------------------------
// mod_147_rx_link_status
// Receive-side status generator for the 10BASE-T1S link monitor.
//   pcs_status     : code-group sync quality (OK=0 / NOT_OK=1), registered
//   loc_rcv_status : debounced signal detect (from mod_147_sd_filter)
// Ports:
//   clk, reset_n (async, active low), pma_reset (sync, active high)
//   signal_detect        raw PMA energy detect
//   rx_sym_valid/rx_sym  one-cycle strobe with a received 5B code-group
//   pcs_status, loc_rcv_status, sync_state (NO_SYNC/SYNC/SYNC_CHECK),
//   bad_cnt (invalid symbols in the current check window, debug)
// ---------------------------------------------------------------------------
module mod_147_rx_link_status
  import mod_147_rx_link_status_pkg::*;
#(
  parameter int unsigned GOOD_LOCK  = 8,
  parameter int unsigned BAD_LIMIT  = 4,
  parameter int unsigned CHK_WIN    = 64,
  parameter int unsigned SD_ON_CYC  = 16,
  parameter int unsigned SD_OFF_CYC = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pma_reset,
  input  logic       signal_detect,
  input  logic       rx_sym_valid,
  input  logic [4:0] rx_sym,
  output logic       pcs_status,
  output logic       loc_rcv_status,
  output logic [1:0] sync_state,
  output logic [7:0] bad_cnt
);

  localparam logic [7:0] GOOD_LOCK_C = 8'(GOOD_LOCK);
  localparam logic [7:0] BAD_LIMIT_C = 8'(BAD_LIMIT);
  localparam logic [9:0] CHK_WIN_C   = 10'(CHK_WIN);

  sync_state_e r_state, w_state_nxt;
  logic [7:0]  r_good, w_good_nxt;
  logic [7:0]  r_bad, w_bad_nxt;
  logic [9:0]  r_win, w_win_nxt;
  logic        r_pcs;
  logic        w_loc;
  logic        w_sym_bad;
  logic [7:0]  w_bad_inc;
  logic [9:0]  w_win_inc;

  mod_147_sd_filter #(
    .SD_ON_CYC  (SD_ON_CYC),
    .SD_OFF_CYC (SD_OFF_CYC)
  ) u_sd_filter (
    .clk            (clk),
    .reset_n        (reset_n),
    .pma_reset      (pma_reset),
    .signal_detect  (signal_detect),
    .loc_rcv_status (w_loc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    w_bad_nxt   = r_bad;
    w_win_nxt   = r_win;
    w_sym_bad   = is_invalid_5b(rx_sym);
    w_bad_inc   = r_bad + 8'(w_sym_bad);
    w_win_inc   = r_win + 10'd1;

    if (!w_loc) begin
      w_state_nxt = NO_SYNC;
      w_good_nxt  = '0;
      w_bad_nxt   = '0;
      w_win_nxt   = '0;
    end else if (rx_sym_valid) begin
      case (r_state)
        NO_SYNC: begin
          if (w_sym_bad) begin
            w_good_nxt = '0;
          end else if (r_good + 8'd1 >= GOOD_LOCK_C) begin
            w_state_nxt = SYNC;
            w_good_nxt  = '0;
          end else begin
            w_good_nxt = r_good + 8'd1;
          end
        end
        SYNC: begin
          if (w_sym_bad) begin
            if (BAD_LIMIT_C <= 8'd1) begin
              w_state_nxt = NO_SYNC;
            end else begin
              w_state_nxt = SYNC_CHECK;
              w_bad_nxt   = 8'd1;
              w_win_nxt   = 10'd1;
            end
          end
        end
        SYNC_CHECK: begin
          // Error limit is tested before window expiry so a limit-reaching
          // error on the last window symbol still drops sync.
          if (w_bad_inc >= BAD_LIMIT_C) begin
            w_state_nxt = NO_SYNC;
            w_bad_nxt   = '0;
            w_win_nxt   = '0;
          end else if (w_win_inc >= CHK_WIN_C) begin
            w_state_nxt = SYNC;
            w_bad_nxt   = '0;
            w_win_nxt   = '0;
          end else begin
            w_bad_nxt = w_bad_inc;
            w_win_nxt = w_win_inc;
          end
        end
        default: begin
          w_state_nxt = NO_SYNC;
          w_good_nxt  = '0;
          w_bad_nxt   = '0;
          w_win_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= NO_SYNC;
      r_good  <= '0;
      r_bad   <= '0;
      r_win   <= '0;
      r_pcs   <= PCS_NOT_OK;
    end else if (pma_reset) begin
      r_state <= NO_SYNC;
      r_good  <= '0;
      r_bad   <= '0;
      r_win   <= '0;
      r_pcs   <= PCS_NOT_OK;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
      r_bad   <= w_bad_nxt;
      r_win   <= w_win_nxt;
      r_pcs   <= (w_state_nxt == NO_SYNC) ? PCS_NOT_OK : PCS_OK;
    end
  end

  // The FSM only sees loc_rcv_status after it is registered in the filter,
  // so the forced-NO_SYNC view is applied on the outputs as well; this makes
  // sync_state/pcs_status/bad_cnt change in the same cycle loc_rcv_status falls.
  assign loc_rcv_status = w_loc;
  assign sync_state     = w_loc ? r_state : NO_SYNC;
  assign pcs_status     = r_pcs | ~w_loc;
  assign bad_cnt        = w_loc ? r_bad : '0;

endmodule

// File: tb/tb_mod_147_rx_link_status.sv
module tb_mod_147_rx_link_status;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pma_reset;
  logic       signal_detect;
  logic       rx_sym_valid;
  logic [4:0] rx_sym;
  logic       pcs_status;
  logic       loc_rcv_status;
  logic [1:0] sync_state;
  logic [7:0] bad_cnt;

  mod_147_rx_link_status #(
    .GOOD_LOCK  (8),
    .BAD_LIMIT  (4),
    .CHK_WIN    (64),
    .SD_ON_CYC  (16),
    .SD_OFF_CYC (32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pma_reset      (pma_reset),
    .signal_detect  (signal_detect),
    .rx_sym_valid   (rx_sym_valid),
    .rx_sym         (rx_sym),
    .pcs_status     (pcs_status),
    .loc_rcv_status (loc_rcv_status),
    .sync_state     (sync_state),
    .bad_cnt        (bad_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] M_PCS = 4'b0001;
  localparam logic [3:0] M_LOC = 4'b0010;
  localparam logic [3:0] M_ST  = 4'b0100;
  localparam logic [3:0] M_BAD = 4'b1000;
  localparam logic [3:0] M_ALL = 4'b1111;

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic       pcs;
    logic       loc;
    logic [1:0] st;
    logic [7:0] bad;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vi       = 0;

  logic [4:0] VALID [24] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                             5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                             5'b11010, 5'b11011, 5'b11100, 5'b11101, 5'b11111, 5'b11000,
                             5'b10001, 5'b01101, 5'b00111, 5'b11001, 5'b00000, 5'b00100};
  logic [4:0] INVAL [8]  = '{5'b00001, 5'b00010, 5'b00011, 5'b00101,
                             5'b00110, 5'b01000, 5'b01100, 5'b10000};

  function automatic void cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  // Monitor: outputs are sampled on the falling edge, half a cycle after the
  // stimulus edge whose effect each queued expectation describes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() != 0) begin
        e = q.pop_front();
        if (e.mask[0]) cmp({e.name, ".pcs"},  {7'd0, pcs_status},     {7'd0, e.pcs});
        if (e.mask[1]) cmp({e.name, ".loc"},  {7'd0, loc_rcv_status}, {7'd0, e.loc});
        if (e.mask[2]) cmp({e.name, ".st"},   {6'd0, sync_state},     {6'd0, e.st});
        if (e.mask[3]) cmp({e.name, ".bad"},  bad_cnt,                e.bad);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string nm, input logic [3:0] m, input logic p, input logic l,
                          input logic [1:0] s, input logic [7:0] b);
    exp_t e;
    e.name = nm; e.mask = m; e.pcs = p; e.loc = l; e.st = s; e.bad = b;
    q.push_back(e);
  endtask

  task automatic send(input logic [4:0] s);
    rx_sym_valid = 1'b1;
    rx_sym       = s;
    step();
    rx_sym_valid = 1'b0;
  endtask

  task automatic send_valid();
    send(VALID[vi]);
    vi = (vi + 1) % 24;
  endtask

  task automatic lock8();
    repeat (8) send_valid();
    expect_o("relock", M_PCS | M_ST, 1'b0, 1'b1, 2'd1, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; pma_reset = 1'b0; signal_detect = 1'b0;
    rx_sym_valid = 1'b0; rx_sym = 5'd0;
    step();
    expect_o("reset", M_ALL, 1'b1, 1'b0, 2'd0, 8'd0);
    reset_n = 1'b1;
    step();
    expect_o("post_reset", M_ALL, 1'b1, 1'b0, 2'd0, 8'd0);

    // 1: debounce thresholds
    signal_detect = 1'b1;
    repeat (15) step();
    expect_o("sd_on_15", M_LOC, 1'b1, 1'b0, 2'd0, 8'd0);
    signal_detect = 1'b0;
    step();
    expect_o("sd_glitch", M_LOC, 1'b1, 1'b0, 2'd0, 8'd0);
    signal_detect = 1'b1;
    repeat (15) step();
    expect_o("sd_on_15b", M_LOC, 1'b1, 1'b0, 2'd0, 8'd0);
    step();
    expect_o("sd_on_16", M_ALL, 1'b1, 1'b1, 2'd0, 8'd0);
    signal_detect = 1'b0;
    repeat (31) step();
    expect_o("sd_off_31", M_LOC, 1'b1, 1'b1, 2'd0, 8'd0);
    step();
    expect_o("sd_off_32", M_LOC, 1'b1, 1'b0, 2'd0, 8'd0);
    signal_detect = 1'b1;
    repeat (16) step();
    expect_o("sd_requal", M_LOC, 1'b1, 1'b1, 2'd0, 8'd0);

    // 2: acquisition; every invalid code breaks a 7-symbol run, every valid code builds one
    for (int k = 0; k < 8; k++) begin
      repeat (7) send_valid();
      send(INVAL[k]);
      expect_o($sformatf("inv_%0d", k), M_PCS | M_ST, 1'b1, 1'b1, 2'd0, 8'd0);
    end
    repeat (7) send_valid();
    rx_sym_valid = 1'b0;
    step();
    expect_o("t2_7valid_hold", M_PCS | M_ST, 1'b1, 1'b1, 2'd0, 8'd0);
    send_valid();
    expect_o("t2_lock", M_PCS | M_ST, 1'b0, 1'b1, 2'd1, 8'd0);

    // 3: three errors in the window, window expires back to SYNC
    send(5'b00010);
    expect_o("t3_sym1", M_ALL, 1'b0, 1'b1, 2'd2, 8'd1);
    for (int s = 2; s <= 64; s++) begin
      if (s == 20 || s == 40) send(5'b01100); else send_valid();
      if (s <= 6) step();
      if (s == 5)  expect_o("t3_gap_hold", M_ST | M_BAD, 1'b0, 1'b1, 2'd2, 8'd1);
      if (s == 40) expect_o("t3_sym40", M_ST | M_BAD, 1'b0, 1'b1, 2'd2, 8'd3);
      if (s == 63) expect_o("t3_sym63", M_ALL, 1'b0, 1'b1, 2'd2, 8'd3);
      if (s == 64) expect_o("t3_expire", M_ALL, 1'b0, 1'b1, 2'd1, 8'd0);
    end

    // 4: four errors inside the window
    send(5'b10000);
    for (int s = 2; s <= 15; s++) begin
      if (s == 5 || s == 10 || s == 15) send(5'b00011); else send_valid();
      if (s == 14) expect_o("t4_sym14", M_ALL, 1'b0, 1'b1, 2'd2, 8'd3);
      if (s == 15) expect_o("t4_drop", M_PCS | M_ST, 1'b1, 1'b1, 2'd0, 8'd0);
    end
    lock8();

    // 5: fourth error on the last window symbol
    for (int s = 1; s <= 64; s++) begin
      if (s <= 3 || s == 64) send(5'b01000); else send_valid();
      if (s == 63) expect_o("t5_sym63", M_ALL, 1'b0, 1'b1, 2'd2, 8'd3);
      if (s == 64) expect_o("t5_limit_wins", M_PCS | M_ST, 1'b1, 1'b1, 2'd0, 8'd0);
    end
    lock8();

    // 6: pma_reset in SYNC_CHECK, then loss of signal while in SYNC
    send(5'b00101);
    expect_o("t6_check", M_ST | M_BAD, 1'b0, 1'b1, 2'd2, 8'd1);
    pma_reset = 1'b1;
    step();
    pma_reset = 1'b0;
    expect_o("t6_pma_reset", M_ALL, 1'b1, 1'b0, 2'd0, 8'd0);
    repeat (15) step();
    expect_o("t6_requal_15", M_LOC, 1'b1, 1'b0, 2'd0, 8'd0);
    step();
    expect_o("t6_requal_16", M_LOC, 1'b1, 1'b1, 2'd0, 8'd0);
    lock8();
    signal_detect = 1'b0;
    repeat (31) step();
    expect_o("t6_off_31", M_ALL, 1'b0, 1'b1, 2'd1, 8'd0);
    step();
    expect_o("t6_off_32", M_ALL, 1'b1, 1'b0, 2'd0, 8'd0);
    repeat (8) send_valid();
    expect_o("t6_ignored", M_PCS | M_ST, 1'b1, 1'b0, 2'd0, 8'd0);
    signal_detect = 1'b1;
    repeat (16) step();
    expect_o("t6_back", M_ALL, 1'b1, 1'b1, 2'd0, 8'd0);

    // Loss of signal on the same edge as the 8th qualifying symbol
    signal_detect = 1'b0;
    repeat (24) step();
    repeat (7) send_valid();
    expect_o("sim_pre", M_ALL, 1'b1, 1'b1, 2'd0, 8'd0);
    send_valid();
    expect_o("sim_fall", M_ALL, 1'b1, 1'b0, 2'd0, 8'd0);
    step();
    expect_o("sim_after", M_ALL, 1'b1, 1'b0, 2'd0, 8'd0);

    repeat (2) step();
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
